// File: rtl/chipout_receiver.sv
// Receive end of the CHIPOUT / DATAREADY strobed interface: synchronise, deglitch,
// capture one word per strobe rising edge and buffer it in a show-ahead FIFO.
module chipout_receiver #(
    parameter int DATA_W        = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 8,
    parameter int ADDR_W        = 3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] CHIPIN,
    input  logic              DATAREADY_IN,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow_flag,
    output logic [7:0]        overflow_count,
    input  logic              clear_overflow
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, WAIT_LOW} state_t;

    logic [DATA_W-1:0]      r_dataSync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_strbSync;
    logic [SYNC_STAGES-1:0] r_primeSr;
    logic                   r_strbPrev;

    logic [DATA_W-1:0] w_syncData;
    logic              w_syncStrb;
    logic              w_rise;
    logic              w_primed;

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_settleCnt;
    logic [CNT_W-1:0]  w_nextCnt;
    logic              w_push;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_count;
    logic              w_full;
    logic              w_pop;
    logic              w_accept;
    logic              w_drop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_dataSync[i] <= '0;
            end
            r_strbSync <= '0;
            r_primeSr  <= '0;
            r_strbPrev <= 1'b0;
        end else begin
            r_dataSync[0] <= CHIPIN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_dataSync[i] <= r_dataSync[i-1];
            end
            r_strbSync <= {r_strbSync[SYNC_STAGES-2:0], DATAREADY_IN};
            r_primeSr  <= {r_primeSr[SYNC_STAGES-2:0], 1'b1};
            r_strbPrev <= w_syncStrb;
        end
    end

    // The synchroniser holds reset zeros for SYNC_STAGES cycles; until those have
    // flushed, a low sync_strb is not real and must not release WAIT_LOW.
    assign w_syncData = r_dataSync[SYNC_STAGES-1];
    assign w_syncStrb = r_strbSync[SYNC_STAGES-1];
    assign w_rise     = w_syncStrb && !r_strbPrev;
    assign w_primed   = r_primeSr[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= WAIT_LOW;
            r_settleCnt <= '0;
        end else begin
            r_state     <= w_nextState;
            r_settleCnt <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_settleCnt;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_nextState = SETTLE;
                    w_nextCnt   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (!w_syncStrb) begin
                    w_nextState = IDLE;
                end else if (r_settleCnt == '0) begin
                    w_nextState = CAPTURE;
                end else begin
                    w_nextCnt = r_settleCnt - CNT_W'(1);
                end
            end
            CAPTURE: begin
                w_push      = 1'b1;
                w_nextState = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (w_primed && !w_syncStrb) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign w_full   = (r_count == (ADDR_W+1)'(FIFO_DEPTH));
    assign w_pop    = data_valid && data_ready;
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_wrPtr] <= w_syncData;
                r_wrPtr        <= r_wrPtr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + ADDR_W'(1);
            end
            r_count <= r_count + (ADDR_W+1)'(w_accept) - (ADDR_W+1)'(w_pop);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow_flag  <= 1'b0;
            overflow_count <= '0;
        end else if (w_drop) begin
            overflow_flag  <= 1'b1;
            if (clear_overflow) begin
                overflow_count <= 8'd1;
            end else if (overflow_count != 8'hFF) begin
                overflow_count <= overflow_count + 8'd1;
            end
        end else if (clear_overflow) begin
            overflow_flag  <= 1'b0;
            overflow_count <= '0;
        end
    end

    assign data_out   = r_mem[r_rdPtr];
    assign data_valid = (r_count != '0);
    assign fifo_count = r_count;

endmodule

// File: tb/tb_chipout_receiver.sv
// Self-checking bench for chipout_receiver: a strobe-length vector table plus
// hand-written sequences, with every popped word checked against a scoreboard queue.
module tb_chipout_receiver;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [4:0] CHIPIN;
    logic       DATAREADY_IN;
    logic [4:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [3:0] fifo_count;
    logic       overflow_flag;
    logic [7:0] overflow_count;
    logic       clear_overflow;

    int         numChecks = 0;
    int         numErrors = 0;
    int         popCount  = 0;
    int         popBefore;
    logic [4:0] scoreQ [$];
    logic [4:0] monExp;

    typedef struct {
        logic [4:0] word;
        int         pulseLen;
        int         expWords;
    } vec_t;

    vec_t vecs [6];

    always #5 CLK = ~CLK;

    chipout_receiver #(
        .DATA_W(5), .SYNC_STAGES(2), .SETTLE_CYCLES(2), .FIFO_DEPTH(8), .ADDR_W(3)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .CHIPIN(CHIPIN),
        .DATAREADY_IN(DATAREADY_IN),
        .data_out(data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .fifo_count(fifo_count),
        .overflow_flag(overflow_flag),
        .overflow_count(overflow_count),
        .clear_overflow(clear_overflow)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Raises the strobe for len sampling edges, then leaves it low long enough to re-arm.
    task automatic applyStimulus(input logic [4:0] word, input int len, input bit expectPush);
        CHIPIN       = word;
        DATAREADY_IN = 1'b1;
        if (expectPush) scoreQ.push_back(word);
        tick(len);
        DATAREADY_IN = 1'b0;
        tick(4);
    endtask

    always @(negedge CLK) begin
        if (RST_N && data_valid && data_ready) begin
            popCount++;
            if (scoreQ.size() == 0) begin
                numChecks++;
                numErrors++;
                $display("[TB] FAIL unexpected_pop: got word %0d, required no word", data_out);
            end else begin
                monExp = scoreQ.pop_front();
                checkOutput("scoreboard_pop", 32'(data_out), 32'(monExp));
            end
        end
    end

    initial begin
        vecs[0] = '{5'h03, 1, 0};
        vecs[1] = '{5'h0C, 2, 0};
        vecs[2] = '{5'h1F, 3, 1};
        vecs[3] = '{5'h00, 6, 1};
        vecs[4] = '{5'h11, 20, 1};
        vecs[5] = '{5'h15, 6, 1};

        RST_N          = 1'b0;
        CHIPIN         = '0;
        DATAREADY_IN   = 1'b0;
        data_ready     = 1'b0;
        clear_overflow = 1'b0;

        tick(2);
        checkOutput("reset_valid", 32'(data_valid), 0);
        checkOutput("reset_count", 32'(fifo_count), 0);
        checkOutput("reset_data", 32'(data_out), 0);
        checkOutput("reset_oflag", 32'(overflow_flag), 0);
        checkOutput("reset_ocount", 32'(overflow_count), 0);
        RST_N = 1'b1;
        tick(5);

        // Single word: valid must appear on the 6th edge after the first sampling edge.
        data_ready   = 1'b1;
        CHIPIN       = 5'h15;
        DATAREADY_IN = 1'b1;
        scoreQ.push_back(5'h15);
        tick(5);
        checkOutput("latency_not_early", 32'(data_valid), 0);
        tick(1);
        checkOutput("latency_valid", 32'(data_valid), 1);
        checkOutput("single_data", 32'(data_out), 'h15);
        DATAREADY_IN = 1'b0;
        tick(1);
        checkOutput("single_drained", 32'(fifo_count), 0);
        checkOutput("single_valid_low", 32'(data_valid), 0);
        tick(4);

        for (int i = 0; i < 6; i++) begin
            popBefore = popCount;
            applyStimulus(vecs[i].word, vecs[i].pulseLen, vecs[i].expWords != 0);
            tick(2);
            checkOutput($sformatf("vec%0d_words", i), 32'(popCount - popBefore), 32'(vecs[i].expWords));
            checkOutput($sformatf("vec%0d_count", i), 32'(fifo_count), 0);
        end

        // Burst under backpressure, then drain in order.
        data_ready = 1'b0;
        for (int w = 1; w <= 8; w++) applyStimulus(5'(w), 3, 1'b1);
        checkOutput("burst_count", 32'(fifo_count), 8);
        checkOutput("burst_head", 32'(data_out), 1);
        popBefore  = popCount;
        data_ready = 1'b1;
        tick(8);
        data_ready = 1'b0;
        checkOutput("burst_pops", 32'(popCount - popBefore), 8);
        checkOutput("burst_drained", 32'(fifo_count), 0);

        // Overflow: ten words into eight slots.
        for (int w = 1; w <= 10; w++) applyStimulus(5'(w), 3, w <= 8);
        checkOutput("ovf_count", 32'(fifo_count), 8);
        checkOutput("ovf_flag", 32'(overflow_flag), 1);
        checkOutput("ovf_drops", 32'(overflow_count), 2);
        checkOutput("ovf_head_stable", 32'(data_out), 1);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        checkOutput("clear_flag", 32'(overflow_flag), 0);
        checkOutput("clear_count", 32'(overflow_count), 0);

        // Full FIFO with a pop in exactly the capture cycle.
        CHIPIN       = 5'h1A;
        DATAREADY_IN = 1'b1;
        scoreQ.push_back(5'h1A);
        tick(5);
        data_ready = 1'b1;
        tick(1);
        data_ready   = 1'b0;
        DATAREADY_IN = 1'b0;
        checkOutput("popush_count", 32'(fifo_count), 8);
        checkOutput("popush_ocount", 32'(overflow_count), 0);
        checkOutput("popush_oflag", 32'(overflow_flag), 0);
        tick(4);

        for (int k = 0; k < 256; k++) applyStimulus(5'(k), 3, 1'b0);
        checkOutput("sat_count", 32'(overflow_count), 255);
        checkOutput("sat_flag", 32'(overflow_flag), 1);

        // Clear lands on the same edge as a drop.
        CHIPIN       = 5'h05;
        DATAREADY_IN = 1'b1;
        tick(5);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        DATAREADY_IN   = 1'b0;
        checkOutput("clrdrop_flag", 32'(overflow_flag), 1);
        checkOutput("clrdrop_count", 32'(overflow_count), 1);
        checkOutput("clrdrop_fifo", 32'(fifo_count), 8);
        tick(4);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        checkOutput("clear2_count", 32'(overflow_count), 0);

        data_ready = 1'b1;
        tick(10);
        data_ready = 1'b0;
        checkOutput("drain_count", 32'(fifo_count), 0);
        checkOutput("drain_queue", 32'(scoreQ.size()), 0);

        // Reset during SETTLE with three words buffered, strobe held across release.
        applyStimulus(5'h07, 3, 1'b1);
        applyStimulus(5'h08, 3, 1'b1);
        applyStimulus(5'h09, 3, 1'b1);
        checkOutput("pre_reset_count", 32'(fifo_count), 3);
        CHIPIN       = 5'h1E;
        DATAREADY_IN = 1'b1;
        tick(3);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("midrst_count", 32'(fifo_count), 0);
        checkOutput("midrst_valid", 32'(data_valid), 0);
        checkOutput("midrst_data", 32'(data_out), 0);
        scoreQ.delete();
        tick(2);
        RST_N = 1'b1;
        tick(12);
        checkOutput("held_strobe_count", 32'(fifo_count), 0);
        checkOutput("held_strobe_valid", 32'(data_valid), 0);
        data_ready   = 1'b1;
        DATAREADY_IN = 1'b0;
        tick(4);
        popBefore = popCount;
        applyStimulus(5'h0B, 3, 1'b1);
        tick(2);
        checkOutput("fresh_strobe_words", 32'(popCount - popBefore), 1);
        checkOutput("fresh_strobe_queue", 32'(scoreQ.size()), 0);

        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule
